viterbi_trellis_scheduler: RTL

//  Sequences the Viterbi decoder datapath for one frame:
//    - fetches each received symbol pair from the symbol buffer;
//    - sweeps the ACS unit over every trellis state for that step;
//    - swaps the path-metric banks;
//    - runs traceback from the last step back to step 0.

---
 rtl/viterbi_trellis_scheduler_if.sv | 33 +++
 rtl/viterbi_trellis_scheduler.sv | 139 +++++++++++++
 2 files changed

// File: rtl/viterbi_trellis_scheduler_if.sv
// Bus between the trellis scheduler and the symbol buffer / ACS / traceback datapath.
// The scheduler drives the strobes and indices; the datapath returns the symbol pair.
interface viterbi_trellis_scheduler_if #(
  parameter int K        = 5,
  parameter int MAX_BITS = 32
);
  localparam int SW = $clog2(MAX_BITS);

  logic          sym_rd_en;
  logic [SW-1:0] sym_rd_addr;
  logic [1:0]    sym_rd_data;
  logic          acs_valid;
  logic [K-2:0]  acs_state;
  logic [1:0]    acs_sym;
  logic [SW-1:0] acs_step;
  logic          bank_swap;
  logic          tb_valid;
  logic [SW-1:0] tb_step;

  modport master (
    output sym_rd_en, sym_rd_addr,
    input  sym_rd_data,
    output acs_valid, acs_state, acs_sym, acs_step, bank_swap,
    output tb_valid, tb_step
  );

  modport slave (
    input  sym_rd_en, sym_rd_addr,
    output sym_rd_data,
    input  acs_valid, acs_state, acs_sym, acs_step, bank_swap,
    input  tb_valid, tb_step
  );
endinterface

// File: rtl/viterbi_trellis_scheduler.sv
// Frame sequencer for the Viterbi datapath: per step fetch symbol, sweep ACS over
// all states, swap metric banks; then trace back from the last step to step 0.
module viterbi_trellis_scheduler #(
  parameter int K        = 5,
  parameter int MAX_BITS = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ena,
  input  logic                        start,
  input  logic                        abort,
  input  logic [$clog2(MAX_BITS):0]   num_bits,
  viterbi_trellis_scheduler_if.master bus,
  output logic                        busy,
  output logic                        frame_done,
  output logic                        cfg_err
);
  localparam int SW  = $clog2(MAX_BITS);
  localparam int SSW = K - 1;
  localparam logic [SW:0]    MAX_LEN    = MAX_BITS[SW:0];
  localparam logic [SSW-1:0] LAST_STATE = {SSW{1'b1}};

  typedef enum logic [2:0] {IDLE, FETCH, LATCH, ACS, SWAP, TB, DONE} state_t;

  state_t         state;
  logic [SW:0]    len;
  logic [SW-1:0]  t;
  logic [SW-1:0]  tb_idx;
  logic [SSW-1:0] acs_cnt;
  logic [1:0]     sym_q;
  logic           rd_en;
  logic           acs_on;
  logic           swap;
  logic           tb_on;
  logic           len_ok;
  logic           last_step;

  assign len_ok    = (num_bits != '0) && (num_bits <= MAX_LEN);
  assign last_step = (({1'b0, t} + 1'b1) == len);

  // Every output is a register; strobes default low each enabled cycle and the
  // next state's strobe is set on the transition into it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      len        <= '0;
      t          <= '0;
      tb_idx     <= '0;
      acs_cnt    <= '0;
      sym_q      <= '0;
      rd_en      <= 1'b0;
      acs_on     <= 1'b0;
      swap       <= 1'b0;
      tb_on      <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      cfg_err    <= 1'b0;
    end else if (ena) begin
      rd_en      <= 1'b0;
      acs_on     <= 1'b0;
      swap       <= 1'b0;
      tb_on      <= 1'b0;
      frame_done <= 1'b0;
      cfg_err    <= 1'b0;
      if (abort && state != IDLE) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start && !abort) begin
              if (len_ok) begin
                len   <= num_bits;
                t     <= '0;
                busy  <= 1'b1;
                rd_en <= 1'b1;
                state <= FETCH;
              end else begin
                cfg_err <= 1'b1;
              end
            end
          end
          FETCH: state <= LATCH;
          LATCH: begin
            sym_q   <= bus.sym_rd_data;
            acs_cnt <= '0;
            acs_on  <= 1'b1;
            state   <= ACS;
          end
          ACS: begin
            if (acs_cnt == LAST_STATE) begin
              swap  <= 1'b1;
              state <= SWAP;
            end else begin
              acs_cnt <= acs_cnt + 1'b1;
              acs_on  <= 1'b1;
            end
          end
          // On the last step t already equals num_bits-1, the first traceback index.
          SWAP: begin
            if (last_step) begin
              tb_idx <= t;
              tb_on  <= 1'b1;
              state  <= TB;
            end else begin
              t     <= t + 1'b1;
              rd_en <= 1'b1;
              state <= FETCH;
            end
          end
          TB: begin
            if (tb_idx == '0) begin
              frame_done <= 1'b1;
              state      <= DONE;
            end else begin
              tb_idx <= tb_idx - 1'b1;
              tb_on  <= 1'b1;
            end
          end
          DONE: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.sym_rd_en   = rd_en;
  assign bus.sym_rd_addr = t;
  assign bus.acs_valid   = acs_on;
  assign bus.acs_state   = acs_cnt;
  assign bus.acs_sym     = sym_q;
  assign bus.acs_step    = t;
  assign bus.bank_swap   = swap;
  assign bus.tb_valid    = tb_on;
  assign bus.tb_step     = tb_idx;
endmodule
